// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC register feeding a 2-entry {instruction, PC} buffer
// towards decode, with redirect/flush and a halt once the PC leaves instruction memory.
module fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PC,
    output logic [31:0] Out_PCPlus4,
    output logic        Halted
);
    typedef enum logic [1:0] {FETCH, FULL, HALTED} state_t;

    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] head_instr, head_pc, tail_instr, tail_pc;

    logic        deq, enq;
    logic [32:0] pc_inc;
    logic [31:0] target;
    logic [1:0]  count_next;

    always_comb begin
        deq        = (count != 2'd0) && Out_Ready;
        enq        = (state == FETCH) && ((count < 2'd2) || deq);
        pc_inc     = {1'b0, pc} + 33'd4;
        target     = RedirectPC & ~32'h3;
        count_next = count + {1'b0, enq} - {1'b0, deq};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc         <= {RESET_PC[31:2], 2'b00};
            count      <= 2'd0;
            state      <= FETCH;
            head_instr <= '0;
            head_pc    <= '0;
            tail_instr <= '0;
            tail_pc    <= '0;
        end else if (Redirect) begin
            // Flush wins over any handshake; head registers keep stale data behind Out_Valid=0.
            pc    <= target;
            count <= 2'd0;
            state <= ({1'b0, target} >= LIMIT) ? HALTED : FETCH;
        end else begin
            // New entry lands in the head only when the buffer is empty after this cycle's pop.
            if (enq && (count == 2'd0 || (count == 2'd1 && deq))) begin
                head_instr <= IM_Instruction;
                head_pc    <= pc;
            end else if (deq && count == 2'd2) begin
                head_instr <= tail_instr;
                head_pc    <= tail_pc;
            end
            if (enq && ((count == 2'd1 && !deq) || count == 2'd2)) begin
                tail_instr <= IM_Instruction;
                tail_pc    <= pc;
            end
            count <= count_next;
            if (enq)
                pc <= pc_inc[31:0];

            if (enq && pc_inc >= LIMIT)
                state <= HALTED;
            else if (state == HALTED)
                state <= HALTED;
            else if (count_next == 2'd2)
                state <= FULL;
            else
                state <= FETCH;
        end
    end

    assign IM_Address      = pc;
    assign Out_Valid       = (count != 2'd0);
    assign Out_Instruction = head_instr;
    assign Out_PC          = head_pc;
    assign Out_PCPlus4     = head_pc + 32'd4;
    assign Halted          = (state == HALTED);
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: DEPTH_WORDS, default 128, instruction memory size in words; valid PC range is 0 .. DEPTH_WORDS*4-4.
REQ-003 Port: Clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset, synchronous, active-high.
REQ-005 Port: IM_Address  output  32  address to instruction memory; equals current PC, word-aligned (bits [1:0] = 0).
REQ-006 Port: IM_Instruction  input  32  combinational read data from instruction memory at IM_Address.
REQ-007 Port: Redirect  input  1  branch/jump taken; load RedirectPC and flush buffered instructions.
REQ-008 Port: RedirectPC  input  32  redirect target.
REQ-009 Port: Out_Valid  output  1  head of fetch buffer holds a valid instruction.
REQ-010 Port: Out_Ready  input  1  decode stage accepts head this cycle.
REQ-011 Port: Out_Instruction  output  32  instruction at buffer head.
REQ-012 Port: Out_PC  output  32  fetch address of head instruction.
REQ-013 Port: Out_PCPlus4  output  32  Out_PC + 4, modulo 2^32.
REQ-014 Port: Halted  output  1  high while in HALTED state.

Function
REQ-015 Block SHALL hold a 32-bit PC register and a 2-entry FIFO of {instruction, PC} pairs, with occupancy count 0..2.
REQ-016 States SHALL be FETCH, FULL, HALTED; encoding is implementer's choice.
REQ-017 Enqueue condition (FETCH only): count<2, or count==2 with Out_Valid && Out_Ready this cycle; on enqueue, {IM_Instruction, PC} SHALL be written at tail and PC <= PC+4.
REQ-018 Dequeue SHALL occur when Out_Valid && Out_Ready; head advances at the clock edge.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-020 Out_Valid SHALL be high iff count != 0; Out_Instruction/Out_PC/Out_PCPlus4 SHALL be driven from head registers and remain stable while Out_Valid && !Out_Ready.
REQ-021 Latency: an instruction at PC in cycle N SHALL appear at the head no earlier than cycle N+1 (registered output, no combinational IM-to-Out path).
REQ-022 Transition FETCH->FULL when count becomes 2; FULL->FETCH when a dequeue occurs without redirect; FULL SHALL NOT enqueue or advance PC.
REQ-023 Transition to HALTED when PC after update would be >= DEPTH_WORDS*4; buffered entries still drain normally; no further enqueue.
REQ-024 Redirect SHALL have priority over all other events: FIFO count <= 0, PC <= {RedirectPC[31:2], 2'b00}, state <= FETCH (or HALTED if the target is out of range); no enqueue and no dequeue take effect that cycle, even if Out_Ready is high.
REQ-025 Redirect in HALTED with an in-range target SHALL resume fetching in FETCH.
REQ-026 IM_Address SHALL equal PC in every state, including HALTED and FULL.
REQ-027 Halted SHALL be high iff state is HALTED.

Reset
REQ-028 On Rst high at a rising edge: PC <= {RESET_PC[31:2], 2'b00}, count <= 0, state <= FETCH, head registers <= 0.
REQ-029 Reset outputs: Out_Valid=0, Out_Instruction=0, Out_PC=0, Out_PCPlus4=4, Halted=0, IM_Address=RESET_PC.
REQ-030 Rst SHALL override Redirect and any handshake in the same cycle; reset mid-stream SHALL discard buffered entries.

Verification
REQ-031 Reset, memory model storage[i]=4*i, Out_Ready=1 -> from cycle 1, Out_Instruction = 0, 4, 8, ... with Out_PC equal to Out_Instruction, one per cycle.
REQ-032 Out_Ready=0 for 5 cycles after reset -> count saturates at 2, state FULL, PC=8, head stays instruction 0 with Out_PC=0; raising Out_Ready yields 0, 4, 8 in order with no gaps or duplicates.
REQ-033 Redirect=1 with RedirectPC=32'h40 while 2 entries are buffered and Out_Ready=1 -> next cycle Out_Valid=0 and PC=0x40; the cycle after, head = 0x40/0x40.
REQ-034 RedirectPC=32'h43 -> PC=0x40 (low bits cleared).
REQ-035 Run to PC=0x1FC with DEPTH_WORDS=128 -> after fetching 0x1FC, Halted=1, IM_Address=0x200, remaining entries drain, then Out_Valid=0; Redirect to 0x10 -> Halted=0 and fetch resumes at 0x10.
REQ-036 Rst asserted together with Redirect while the FIFO is full -> PC=RESET_PC, Out_Valid=0, state FETCH.
